ysyx_22050058_ifu: RTL

Instruction fetch unit: owns the architectural PC and fetches one 32-bit instruction at a time over a request/grant/response instruction-memory port. It presents each fetched instruction with its PC to the IF/ID pipeline register. It honours the pipeline-controller stall vector and redirects on branch or jump. While no instruction is available it drives a bubble (zero PC, zero instruction) and raises a stall request.

---
 rtl/ysyx_22050058_ifu.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ysyx_22050058_ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time over a
// req/gnt/rvalid port and presents it to IF/ID, honouring stall and redirect.
module ysyx_22050058_ifu #(
   parameter int unsigned       ADDR_W     = 64,
   parameter int unsigned       INST_W     = 32,
   parameter logic [ADDR_W-1:0] RST_VECTOR = 64'h8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic              redirect_en_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_gnt_i,
   input  logic              imem_rvalid_i,
   input  logic [INST_W-1:0] imem_rdata_i,
   output logic [ADDR_W-1:0] if_pc_o,
   output logic [INST_W-1:0] if_inst_o,
   output logic              if_valid_o,
   output logic              stallreq_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [INST_W-1:0] r_inst;
   logic              r_kill;
   logic              r_req;
   logic              r_valid;
   logic [ADDR_W-1:0] r_if_pc;
   logic [INST_W-1:0] r_if_inst;

   state_t            w_state_next;
   logic [ADDR_W-1:0] w_pc_next;
   logic [INST_W-1:0] w_inst_next;
   logic              w_kill_next;
   logic              w_req_next;
   logic              w_valid_next;
   logic [ADDR_W-1:0] w_if_pc_next;
   logic [INST_W-1:0] w_if_inst_next;
   logic [ADDR_W-1:0] w_redirect_tgt;
   logic [ADDR_W-1:0] w_pc_inc;
   logic              w_hold_fetch;
   logic              w_unused;

   // Targets are word aligned; the low two bits of the redirect are dropped.
   assign w_redirect_tgt = {redirect_pc_i[ADDR_W-1:2], 2'b00};
   assign w_pc_inc       = r_pc + ADDR_W'(4);
   assign w_hold_fetch   = stall[0];
   assign w_unused       = ^{stall[5:1], redirect_pc_i[1:0]};

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_inst_next  = r_inst;
      w_kill_next  = r_kill;
      case (r_state)
         S_IDLE: begin
            w_state_next = S_REQ;
         end
         S_REQ: begin
            if (redirect_en_i) begin
               w_pc_next = w_redirect_tgt;
            end
            if (imem_gnt_i) begin
               // An old address accepted alongside a redirect must be discarded.
               w_state_next = S_WAIT;
               w_kill_next  = redirect_en_i;
            end
         end
         S_WAIT: begin
            if (imem_rvalid_i) begin
               if (redirect_en_i) begin
                  w_pc_next    = w_redirect_tgt;
                  w_kill_next  = 1'b0;
                  w_state_next = S_REQ;
               end else if (r_kill) begin
                  w_kill_next  = 1'b0;
                  w_state_next = S_REQ;
               end else begin
                  w_inst_next  = imem_rdata_i;
                  w_state_next = S_HOLD;
               end
            end else if (redirect_en_i) begin
               w_pc_next   = w_redirect_tgt;
               w_kill_next = 1'b1;
            end
         end
         S_HOLD: begin
            // Redirect outranks the stall: the held instruction is on a dead path.
            if (redirect_en_i) begin
               w_pc_next    = w_redirect_tgt;
               w_state_next = S_REQ;
            end else if (!w_hold_fetch) begin
               w_pc_next    = w_pc_inc;
               w_state_next = S_REQ;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_req_next     = (w_state_next == S_REQ);
      w_valid_next   = (w_state_next == S_HOLD);
      w_if_pc_next   = w_valid_next ? w_pc_next : '0;
      w_if_inst_next = w_valid_next ? w_inst_next : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_pc      <= RST_VECTOR;
         r_inst    <= '0;
         r_kill    <= 1'b0;
         r_req     <= 1'b0;
         r_valid   <= 1'b0;
         r_if_pc   <= '0;
         r_if_inst <= '0;
      end else begin
         r_state   <= w_state_next;
         r_pc      <= w_pc_next;
         r_inst    <= w_inst_next;
         r_kill    <= w_kill_next;
         r_req     <= w_req_next;
         r_valid   <= w_valid_next;
         r_if_pc   <= w_if_pc_next;
         r_if_inst <= w_if_inst_next;
      end
   end

   assign imem_req_o  = r_req;
   assign imem_addr_o = r_pc;
   assign if_valid_o  = r_valid;
   assign if_pc_o     = r_if_pc;
   assign if_inst_o   = r_if_inst;
   assign stallreq_o  = ~r_valid;

endmodule
